// File: rtl/vga_paged_display.sv
// 640x480@60 Hz VGA scan generator for a 1-bpp, page-organised framebuffer.
// Every output (colour, syncs, frame pulse) lags the scan counters by RAM_LATENCY+1 clocks.
module vga_paged_display #(
    parameter int unsigned H_SCALE     = 5,
    parameter int unsigned V_SCALE     = 5,
    parameter int unsigned RAM_LATENCY = 1,
    parameter logic [2:0]  FG_COLOR    = 3'b110,
    parameter logic [2:0]  BG_COLOR    = 3'b001,
    localparam int unsigned COLS       = 640 / H_SCALE,
    localparam int unsigned ROWS       = 480 / V_SCALE,
    localparam int unsigned AW         = $clog2(COLS * ROWS / 8)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Enable_i,
    input  logic          Invert_i,
    output logic [AW-1:0] RequestedAddress_o,
    input  logic [7:0]    DataFromRAM_i,
    output logic          Red_o,
    output logic          Green_o,
    output logic          Blue_o,
    output logic          HSync_o,
    output logic          VSync_o,
    output logic          VBlank_o,
    output logic          FrameStart_o
);

    localparam logic [9:0] H_LAST    = 10'd799;
    localparam logic [9:0] V_LAST    = 10'd524;
    localparam logic [9:0] HDIV_LAST = 10'(H_SCALE - 1);
    localparam logic [9:0] VDIV_LAST = 10'(V_SCALE - 1);

    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_div, v_div;
    logic [9:0] h_pix, v_pix;
    logic       inv_latched;

    logic active, pix_on, hs_raw, vs_raw, fs_raw;

    logic [RAM_LATENCY-1:0] on_pipe, hs_pipe, vs_pipe, fs_pipe;
    logic [2:0]             bit_pipe [RAM_LATENCY];
    logic                   pix_bit;

    // Stage 0: scan position, framebuffer pixel position and RAM address
    always_ff @(posedge Clock) begin
        if (Reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_div       <= '0;
            v_div       <= '0;
            h_pix       <= '0;
            v_pix       <= '0;
            inv_latched <= 1'b0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            h_div <= '0;
            h_pix <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt       <= '0;
                v_div       <= '0;
                v_pix       <= '0;
                inv_latched <= Invert_i;
            end else begin
                v_cnt <= v_cnt + 10'd1;
                if (v_div == VDIV_LAST) begin
                    v_div <= '0;
                    v_pix <= v_pix + 10'd1;
                end else begin
                    v_div <= v_div + 10'd1;
                end
            end
        end else begin
            h_cnt <= h_cnt + 10'd1;
            if (h_div == HDIV_LAST) begin
                h_div <= '0;
                h_pix <= h_pix + 10'd1;
            end else begin
                h_div <= h_div + 10'd1;
            end
        end
    end

    always_comb begin
        active = (h_cnt < 10'd640) && (v_cnt < 10'd480);
        pix_on = active && Enable_i;
        hs_raw = !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
        vs_raw = !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
        fs_raw = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        // Page index (8 fb rows per page) selects the column-major byte block
        RequestedAddress_o = active ? (AW'(v_pix >> 3) * AW'(COLS) + AW'(h_pix)) : '0;
    end

    // RAM_LATENCY stages keep per-pixel control aligned with the returning RAM byte
    always_ff @(posedge Clock) begin
        if (Reset) begin
            on_pipe <= '0;
            hs_pipe <= '1;
            vs_pipe <= '1;
            fs_pipe <= '0;
            for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
                bit_pipe[i] <= '0;
            end
        end else begin
            on_pipe[0]  <= pix_on;
            hs_pipe[0]  <= hs_raw;
            vs_pipe[0]  <= vs_raw;
            fs_pipe[0]  <= fs_raw;
            bit_pipe[0] <= v_pix[2:0];
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                on_pipe[i]  <= on_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                fs_pipe[i]  <= fs_pipe[i-1];
                bit_pipe[i] <= bit_pipe[i-1];
            end
        end
    end

    always_comb begin
        pix_bit = DataFromRAM_i[bit_pipe[RAM_LATENCY-1]] ^ inv_latched;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            {Red_o, Green_o, Blue_o} <= 3'b000;
            HSync_o                  <= 1'b1;
            VSync_o                  <= 1'b1;
            VBlank_o                 <= 1'b0;
            FrameStart_o             <= 1'b0;
        end else begin
            {Red_o, Green_o, Blue_o} <= on_pipe[RAM_LATENCY-1] ?
                                        (pix_bit ? FG_COLOR : BG_COLOR) : 3'b000;
            HSync_o                  <= hs_pipe[RAM_LATENCY-1];
            VSync_o                  <= vs_pipe[RAM_LATENCY-1];
            FrameStart_o             <= fs_pipe[RAM_LATENCY-1];
            // Blanking flag tracks the scan counters directly, not the output pipeline
            VBlank_o                 <= (v_cnt >= 10'd480);
        end
    end

endmodule
